// File: rtl/if_id_stage_pkg.sv
// Shared constants, IF/ID action encoding and address helper for the fetch stage.
package if_id_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'h0000_0004;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // What the IF/ID latch does at the next edge.
  typedef enum logic [1:0] {
    IFID_HOLD  = 2'd0,
    IFID_FLUSH = 2'd1,
    IFID_LOAD  = 2'd2
  } ifid_action_e;

  // Word-align a fetch address; instruction fetch never uses the low two bits.
  function automatic logic [31:0] align_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_stage_if_id_reg.sv
// IF/ID pipeline latch: holds, squashes to a bubble, or loads the fetched word.
module if_id_reg
  import if_id_stage_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  ifid_action_e i_action,
  input  logic [31:0]  i_instr,
  input  logic [31:0]  i_pc4,
  output logic [31:0]  o_instr,
  output logic [31:0]  o_pc4,
  output logic         o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;

  // Latch update: reset clears to a bubble, otherwise apply the requested action.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'h0000_0000;
      r_valid <= 1'b0;
    end else begin
      case (i_action)
        IFID_HOLD: begin
          r_instr <= r_instr;
          r_pc4   <= r_pc4;
          r_valid <= r_valid;
        end
        IFID_FLUSH: begin
          r_instr <= NOP_INSTR;
          r_pc4   <= 32'h0000_0000;
          r_valid <= 1'b0;
        end
        IFID_LOAD: begin
          r_instr <= i_instr;
          r_pc4   <= i_pc4;
          r_valid <= 1'b1;
        end
        default: begin
          r_instr <= r_instr;
          r_pc4   <= r_pc4;
          r_valid <= r_valid;
        end
      endcase
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage: PC register with stall/redirect priority, IF/ID latch
// and saturating stall/flush event counters. All outputs come straight from flops.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             pc_stall_i,
  input  logic             stall_hold_i,
  input  logic             flush_i,
  input  logic             branch_i,
  input  logic [31:0]      branch_addr_i,
  input  logic             jump_i,
  input  logic [31:0]      jump_addr_i,
  input  logic [31:0]      instr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      if_id_instr_o,
  output logic [31:0]      if_id_pc4_o,
  output logic             if_id_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_pc_next;
  ifid_action_e     w_action;
  logic             w_stall_event;
  logic             w_flush_event;

  // 32-bit add drops the carry, so 0xFFFF_FFFC wraps to 0.
  assign w_pc_plus4 = r_pc + PC_INC;

  // Next PC: hold on stall, otherwise jump beats branch beats sequential fetch.
  always_comb begin
    w_pc_next = r_pc;
    if (start_i) begin
      if (pc_stall_i) begin
        w_pc_next = r_pc;
      end else if (jump_i) begin
        w_pc_next = align_addr(jump_addr_i);
      end else if (branch_i) begin
        w_pc_next = align_addr(branch_addr_i);
      end else begin
        w_pc_next = w_pc_plus4;
      end
    end else begin
      w_pc_next = r_pc;
    end
  end

  // PC register; reset always restarts fetch at the (aligned) reset vector.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc <= align_addr(RESET_PC);
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // IF/ID action: hold beats flush beats load; frozen when not running.
  always_comb begin
    w_action = IFID_HOLD;
    if (start_i) begin
      if (stall_hold_i) begin
        w_action = IFID_HOLD;
      end else if (flush_i) begin
        w_action = IFID_FLUSH;
      end else begin
        w_action = IFID_LOAD;
      end
    end else begin
      w_action = IFID_HOLD;
    end
  end

  // A flush that loses to a stall is not applied, hence not counted.
  assign w_stall_event = start_i & stall_hold_i;
  assign w_flush_event = start_i & ~stall_hold_i & flush_i;

  // Stall counter, saturating at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= CNT_ZERO;
    end else if (w_stall_event && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  // Flush counter, saturating at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_flush_cnt <= CNT_ZERO;
    end else if (w_flush_event && (r_flush_cnt != CNT_MAX)) begin
      r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end else begin
      r_flush_cnt <= r_flush_cnt;
    end
  end

  if_id_reg u_if_id_reg (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_action (w_action),
    .i_instr  (instr_i),
    .i_pc4    (w_pc_plus4),
    .o_instr  (if_id_instr_o),
    .o_pc4    (if_id_pc4_o),
    .o_valid  (if_id_valid_o)
  );

  assign pc_o        = r_pc;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: the driver pushes expected post-edge state
// from a behavioural model; a monitor pops and compares after every rising edge.
// A second instance with a 3-bit counter width exercises counter saturation.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        pc_stall_i = 1'b0;
  logic        stall_hold_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = 32'h0;
  logic        jump_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic [31:0] instr_i = 32'h0;

  logic [31:0] pc_o, if_id_instr_o, if_id_pc4_o;
  logic        if_id_valid_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  logic [31:0] s_pc_o, s_instr_o, s_pc4_o;
  logic        s_valid_o;
  logic [2:0]  s_stall_cnt_o, s_flush_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .pc_stall_i(pc_stall_i),
    .stall_hold_i(stall_hold_i), .flush_i(flush_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .instr_i(instr_i), .pc_o(pc_o), .if_id_instr_o(if_id_instr_o),
    .if_id_pc4_o(if_id_pc4_o), .if_id_valid_o(if_id_valid_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  if_id_stage #(.CNT_W(3)) dut_sat (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .pc_stall_i(pc_stall_i),
    .stall_hold_i(stall_hold_i), .flush_i(flush_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .instr_i(instr_i), .pc_o(s_pc_o), .if_id_instr_o(s_instr_o),
    .if_id_pc4_o(s_pc4_o), .if_id_valid_o(s_valid_o),
    .stall_cnt_o(s_stall_cnt_o), .flush_cnt_o(s_flush_cnt_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    int          stalls;
    int          flushes;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: architectural meaning only, counters kept unbounded.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_stalls, m_flushes;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Drive one cycle's inputs (called at a falling edge), predict, then advance.
  task automatic cycle(input logic rs, input logic st, input logic ps, input logic sh,
                       input logic fl, input logic br, input logic [31:0] ba,
                       input logic jp, input logic [31:0] ja);
    exp_t e;
    logic [31:0] seq;
    rst_i = rs; start_i = st; pc_stall_i = ps; stall_hold_i = sh; flush_i = fl;
    branch_i = br; branch_addr_i = ba; jump_i = jp; jump_addr_i = ja;
    instr_i = $urandom;
    if (rs) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_stalls = 0; m_flushes = 0;
    end else if (st) begin
      seq = m_pc + 32'd4;
      if (sh) begin
        m_stalls++;
      end else if (fl) begin
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_flushes++;
      end else begin
        m_instr = instr_i; m_pc4 = seq; m_valid = 1'b1;
      end
      if (ps)      m_pc = m_pc;
      else if (jp) m_pc = ja & 32'hFFFF_FFFC;
      else if (br) m_pc = ba & 32'hFFFF_FFFC;
      else         m_pc = seq;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
    e.stalls = m_stalls; e.flushes = m_flushes;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: after every rising edge compare DUT state with the oldest prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc_o", pc_o, e.pc);
      chk("if_id_instr_o", if_id_instr_o, e.instr);
      chk("if_id_pc4_o", if_id_pc4_o, e.pc4);
      chk("if_id_valid_o", {31'h0, if_id_valid_o}, {31'h0, e.valid});
      chk("stall_cnt_o", {16'h0, stall_cnt_o}, sat(e.stalls, 65535));
      chk("flush_cnt_o", {16'h0, flush_cnt_o}, sat(e.flushes, 65535));
      chk("sat_stall_cnt", {29'h0, s_stall_cnt_o}, sat(e.stalls, 7));
      chk("sat_flush_cnt", {29'h0, s_flush_cnt_o}, sat(e.flushes, 7));
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    @(negedge clk);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("reset_pc", pc_o, 32'h0);
    chk("reset_valid", {31'h0, if_id_valid_o}, 32'h0);

    // Sequential fetch from reset
    run(3);
    chk("seq_pc", pc_o, 32'h0000_000C);
    chk("seq_pc4", if_id_pc4_o, 32'h0000_000C);
    chk("seq_valid", {31'h0, if_id_valid_o}, 32'h1);

    // Two-cycle stall at 0x10, then resume
    run(1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("stall_pc", pc_o, 32'h0000_0010);
    chk("stall_pc4", if_id_pc4_o, 32'h0000_0010);
    chk("stall_cnt", {16'h0, stall_cnt_o}, 32'd2);
    run(1);
    chk("resume_pc", pc_o, 32'h0000_0014);

    // Taken branch with flush at 0x20, unaligned target
    run(3);
    chk("pre_branch_pc", pc_o, 32'h0000_0020);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'h0);
    chk("branch_pc", pc_o, 32'h0000_0100);
    chk("flush_instr", if_id_instr_o, 32'h0);
    chk("flush_valid", {31'h0, if_id_valid_o}, 32'h0);
    chk("flush_cnt", {16'h0, flush_cnt_o}, 32'd1);

    // Stall beats redirect and flush; next cycle the jump wins
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0301);
    chk("stall_vs_redir_pc", pc_o, 32'h0000_0100);
    chk("stall_vs_flush_cnt", {16'h0, flush_cnt_o}, 32'd1);
    chk("stall_vs_stall_cnt", {16'h0, stall_cnt_o}, 32'd3);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0301);
    chk("jump_wins_pc", pc_o, 32'h0000_0300);

    // start_i low freezes everything
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0500);
    chk("frozen_pc", pc_o, 32'h0000_0300);

    // Wrap at the top of the address space
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
    chk("wrap_pre_pc", pc_o, 32'hFFFF_FFFC);
    run(1);
    chk("wrap_pc", pc_o, 32'h0);
    chk("wrap_pc4", if_id_pc4_o, 32'h0);

    // Drive the small-counter instance into saturation
    for (int k = 0; k < 9; k++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("sat_stall_hold", {29'h0, s_stall_cnt_o}, 32'd7);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("sat_flush_hold", {29'h0, s_flush_cnt_o}, 32'd7);

    // Reset in the middle of a stall
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0080);
    chk("rst_stall_pc", pc_o, 32'h0);
    chk("rst_stall_cnt", {16'h0, stall_cnt_o}, 32'd0);
    chk("rst_flush_cnt", {16'h0, flush_cnt_o}, 32'd0);
    chk("rst_instr", if_id_instr_o, 32'h0);
    run(1);
    chk("post_rst_pc4", if_id_pc4_o, 32'h0000_0004);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0), $urandom,
            ($urandom_range(0, 6) == 0), $urandom);
    end

    // Let the monitor drain the scoreboard (bounded)
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
